// File: rtl/ar_decoder_nslv_pkg.sv
// Shared types and constants for the AXI read-address decoder and its default slave.
// Also provides the address-to-slave index function used by the decoder and its bench.
package axi_dec_pkg;

    typedef enum logic {D_IDLE, D_RESP} dslv_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Slave i owns the window [i*region_size, (i+1)*region_size-1].
    function automatic logic [63:0] slv_idx(input logic [63:0] addr, input logic [63:0] region_size);
        return addr / region_size;
    endfunction

endpackage

// File: rtl/ar_decoder_nslv_if.sv
// AR fan-out bundle: upstream AR, per-slave AR, default-slave R channel and the sticky flag.
// The master modport is the environment side; the slave modport is the decoder side.
interface ar_decoder_nslv_if #(
    parameter int NUM_SLAVES = 2,
    parameter int ID_W       = 8,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 4,
    parameter int SIZE_W     = 3,
    parameter int DATA_W     = 32
);
    logic [ID_W-1:0]              ARID;
    logic [ADDR_W-1:0]            ARADDR;
    logic [LEN_W-1:0]             ARLEN;
    logic [SIZE_W-1:0]            ARSIZE;
    logic [1:0]                   ARBURST;
    logic                         ARVALID;
    logic                         ARREADY;

    logic [NUM_SLAVES*ID_W-1:0]   ARID_S;
    logic [NUM_SLAVES*ADDR_W-1:0] ARADDR_S;
    logic [NUM_SLAVES*LEN_W-1:0]  ARLEN_S;
    logic [NUM_SLAVES*SIZE_W-1:0] ARSIZE_S;
    logic [NUM_SLAVES*2-1:0]      ARBURST_S;
    logic [NUM_SLAVES-1:0]        ARVALID_S;
    logic [NUM_SLAVES-1:0]        ARREADY_S;

    logic [ID_W-1:0]              RID_D;
    logic [DATA_W-1:0]            RDATA_D;
    logic [1:0]                   RRESP_D;
    logic                         RLAST_D;
    logic                         RVALID_D;
    logic                         RREADY_D;

    logic                         decerr_sticky;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY_S, RREADY_D,
        input  ARREADY, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D, decerr_sticky
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY_S, RREADY_D,
        output ARREADY, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D, decerr_sticky
    );

endinterface

// File: rtl/ar_decoder_nslv_default_slave.sv
// Default slave for unmapped reads: answers each taken request with ARLEN+1 DECERR beats.
// i_take may only be asserted while o_idle is high.
module ar_default_slave
    import axi_dec_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_take,
    input  logic [ID_W-1:0]   i_id,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_idle,
    input  logic              i_rready,
    output logic              o_rvalid,
    output logic [ID_W-1:0]   o_rid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rlast
);

    dslv_state_t      r_state;
    dslv_state_t      w_next;
    logic [ID_W-1:0]  r_id;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat;

    assign o_idle = (r_state == D_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= D_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (i_take) begin
                r_id   <= i_id;
                r_len  <= i_len;
                r_beat <= '0;
            end else if (o_rvalid && i_rready && !o_rlast) begin
                r_beat <= r_beat + LEN_W'(1);
            end
        end
    end

    // The beat counter stops at r_len, so a full-length burst never wraps it.
    always_comb begin
        w_next   = r_state;
        o_rvalid = 1'b0;
        o_rid    = '0;
        o_rdata  = '0;
        o_rresp  = RESP_OKAY;
        o_rlast  = 1'b0;
        case (r_state)
            D_IDLE: begin
                if (i_take) w_next = D_RESP;
            end
            D_RESP: begin
                o_rvalid = 1'b1;
                o_rid    = r_id;
                o_rresp  = RESP_DECERR;
                o_rlast  = (r_beat == r_len);
                if (i_rready && o_rlast) w_next = D_IDLE;
            end
            default: w_next = D_IDLE;
        endcase
    end

endmodule

// File: rtl/ar_decoder_nslv.sv
// AXI AR decoder: one-entry request slice, address decode and one-hot ARVALID fan-out.
// Define DECERR_EN to include the DECERR default slave; otherwise unmapped requests just drain.
module ar_decoder_nslv
    import axi_dec_pkg::*;
#(
    parameter int          NUM_SLAVES  = 2,
    parameter int          ID_W        = 8,
    parameter int          ADDR_W      = 32,
    parameter int          LEN_W       = 4,
    parameter int          SIZE_W      = 3,
    parameter int          DATA_W      = 32,
    parameter int unsigned REGION_SIZE = 32'h1_0000
) (
    input logic               ACLK,
    input logic               ARESETn,
    ar_decoder_nslv_if.slave  bus
);

    logic                  r_full;
    logic [ID_W-1:0]       r_id;
    logic [ADDR_W-1:0]     r_addr;
    logic [LEN_W-1:0]      r_len;
    logic [SIZE_W-1:0]     r_size;
    logic [1:0]            r_burst;
    logic                  r_sticky;

    logic [63:0]           w_idx;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_slave_rdy;
    logic                  w_dflt_rdy;
    logic                  w_drain;
    logic                  w_load;
    logic                  w_decerr_take;

    always_comb begin
        w_idx    = slv_idx(64'(r_addr), 64'(REGION_SIZE));
        w_mapped = (w_idx < 64'(NUM_SLAVES));
        w_sel    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel[i] = w_mapped && (w_idx == 64'(i));
        end
    end

    // Draining and loading in the same cycle keeps the slice full at full throughput.
    assign w_slave_rdy   = |(w_sel & bus.ARREADY_S);
    assign w_drain       = r_full && (w_mapped ? w_slave_rdy : w_dflt_rdy);
    assign w_decerr_take = r_full && !w_mapped && w_drain;
    assign bus.ARREADY   = !r_full || w_drain;
    assign w_load        = bus.ARVALID && bus.ARREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_full   <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_load) begin
                r_full  <= 1'b1;
                r_id    <= bus.ARID;
                r_addr  <= bus.ARADDR;
                r_len   <= bus.ARLEN;
                r_size  <= bus.ARSIZE;
                r_burst <= bus.ARBURST;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            if (w_decerr_take) r_sticky <= 1'b1;
        end
    end

    assign bus.ARVALID_S     = r_full ? w_sel : '0;
    assign bus.ARID_S        = {NUM_SLAVES{r_id}};
    assign bus.ARADDR_S      = {NUM_SLAVES{r_addr}};
    assign bus.ARLEN_S       = {NUM_SLAVES{r_len}};
    assign bus.ARSIZE_S      = {NUM_SLAVES{r_size}};
    assign bus.ARBURST_S     = {NUM_SLAVES{r_burst}};
    assign bus.decerr_sticky = r_sticky;

`ifdef DECERR_EN
    ar_default_slave #(
        .ID_W   (ID_W),
        .LEN_W  (LEN_W),
        .DATA_W (DATA_W)
    ) u_default_slave (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .i_take   (w_decerr_take),
        .i_id     (r_id),
        .i_len    (r_len),
        .o_idle   (w_dflt_rdy),
        .i_rready (bus.RREADY_D),
        .o_rvalid (bus.RVALID_D),
        .o_rid    (bus.RID_D),
        .o_rdata  (bus.RDATA_D),
        .o_rresp  (bus.RRESP_D),
        .o_rlast  (bus.RLAST_D)
    );
`else
    logic w_unused_rready;

    assign w_unused_rready = bus.RREADY_D;
    assign w_dflt_rdy      = 1'b1;
    assign bus.RVALID_D    = 1'b0;
    assign bus.RID_D       = '0;
    assign bus.RDATA_D     = {DATA_W{1'b0}};
    assign bus.RRESP_D     = RESP_OKAY;
    assign bus.RLAST_D     = 1'b0;
`endif

endmodule

// File: tb/tb_ar_decoder_nslv.sv
// Self-checking bench for ar_decoder_nslv: directed steps followed by a randomized run
// checked against a queue-based model of which slave (or the DECERR responder) gets each read.
module tb_ar_decoder_nslv;
    import axi_dec_pkg::*;

    localparam int          NS     = 2;
    localparam int unsigned REGION = 32'h1_0000;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          tgt;
    } req_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;

    ar_decoder_nslv_if #(.NUM_SLAVES(NS), .ID_W(8), .ADDR_W(32), .LEN_W(4), .SIZE_W(3), .DATA_W(32)) bus ();

    ar_decoder_nslv #(
        .NUM_SLAVES(NS), .ID_W(8), .ADDR_W(32), .LEN_W(4), .SIZE_W(3), .DATA_W(32), .REGION_SIZE(REGION)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int      checks = 0;
    int      errors = 0;
    bit      monEn = 1'b0;
    bit      rndReady = 1'b0;
    req_t    mapQ[$];
    req_t    errQ[$];
    req_t    e;
    int      beatCnt = 0;
    logic [NS-1:0] prevPend = '0;
    logic [31:0]   prevAddr [NS];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; a further unit lets combinational outputs settle.
    task automatic stepCycle();
        @(posedge ACLK);
        #1;
        if (rndReady) begin
            bus.ARREADY_S = NS'($urandom_range(0, (1 << NS) - 1));
            bus.RREADY_D  = 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    function automatic int expTgt(input logic [31:0] a);
        return int'(a / REGION);
    endfunction

    task automatic drive(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        bus.ARID    = id;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        bus.ARSIZE  = 3'd2;
        bus.ARBURST = BURST_INCR;
        bus.ARVALID = 1'b1;
    endtask

    task automatic applyStimulus(input req_t r);
        bus.ARID    = r.id;
        bus.ARADDR  = r.addr;
        bus.ARLEN   = r.len;
        bus.ARSIZE  = r.size;
        bus.ARBURST = r.burst;
        bus.ARVALID = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.ARREADY === 1'b1) begin
                if (r.tgt < NS) mapQ.push_back(r);
`ifdef DECERR_EN
                else errQ.push_back(r);
`endif
                stepCycle();
                bus.ARVALID = 1'b0;
                return;
            end
            stepCycle();
        end
        checkOutput("arready_timeout", 64'(bus.ARREADY), 64'd1);
        bus.ARVALID = 1'b0;
    endtask

    // Scoreboard: each slave handshake and each DECERR beat is matched against the model queues.
    always @(negedge ACLK) begin
        if (monEn) begin
            checkOutput("valid_onehot", 64'($countones(bus.ARVALID_S) <= 1), 64'd1);
            for (int i = 0; i < NS; i++) begin
                if (prevPend[i]) begin
                    checkOutput("hold_valid", 64'(bus.ARVALID_S[i]), 64'd1);
                    checkOutput("hold_addr", 64'(bus.ARADDR_S[i*32 +: 32]), 64'(prevAddr[i]));
                end
                if (bus.ARVALID_S[i] && bus.ARREADY_S[i]) begin
                    if (mapQ.size() == 0) begin
                        checkOutput("ar_unexpected", 64'(mapQ.size()), 64'd1);
                    end else begin
                        e = mapQ.pop_front();
                        checkOutput("ar_target", 64'(i), 64'(e.tgt));
                        checkOutput("ar_addr", 64'(bus.ARADDR_S[i*32 +: 32]), 64'(e.addr));
                        checkOutput("ar_id", 64'(bus.ARID_S[i*8 +: 8]), 64'(e.id));
                        checkOutput("ar_len", 64'(bus.ARLEN_S[i*4 +: 4]), 64'(e.len));
                        checkOutput("ar_size", 64'(bus.ARSIZE_S[i*3 +: 3]), 64'(e.size));
                        checkOutput("ar_burst", 64'(bus.ARBURST_S[i*2 +: 2]), 64'(e.burst));
                    end
                end
                prevPend[i] = bus.ARVALID_S[i] && !bus.ARREADY_S[i];
                prevAddr[i] = bus.ARADDR_S[i*32 +: 32];
            end
`ifdef DECERR_EN
            if (bus.RVALID_D && bus.RREADY_D) begin
                if (errQ.size() == 0) begin
                    checkOutput("r_unexpected", 64'(errQ.size()), 64'd1);
                end else begin
                    checkOutput("r_id", 64'(bus.RID_D), 64'(errQ[0].id));
                    checkOutput("r_resp", 64'(bus.RRESP_D), 64'(RESP_DECERR));
                    checkOutput("r_data", 64'(bus.RDATA_D), 64'd0);
                    checkOutput("r_last", 64'(bus.RLAST_D), 64'(beatCnt == int'(errQ[0].len)));
                    if (beatCnt == int'(errQ[0].len)) begin
                        void'(errQ.pop_front());
                        beatCnt = 0;
                    end else begin
                        beatCnt++;
                    end
                end
            end
`else
            checkOutput("r_silent", 64'(bus.RVALID_D), 64'd0);
`endif
        end
    end

    initial begin
        logic [31:0] t4Addr [4];
        logic [1:0]  t4Sel  [4];
        int          beats;
        req_t        r;

        t4Addr = '{32'h0000_0100, 32'h0001_0100, 32'h0000_0200, 32'h0001_FFFF};
        t4Sel  = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'd2;
        bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b0;
        bus.ARREADY_S = '0; bus.RREADY_D = 1'b0;

        $display("[TB] reset");
        ARESETn = 1'b0;
        bus.ARVALID = 1'b1;
        bus.ARADDR = 32'h0000_1234;
        repeat (3) stepCycle();
        checkOutput("rst_arready", 64'(bus.ARREADY), 64'd1);
        checkOutput("rst_arvalid_s", 64'(bus.ARVALID_S), 64'd0);
        checkOutput("rst_rvalid_d", 64'(bus.RVALID_D), 64'd0);
        checkOutput("rst_sticky", 64'(bus.decerr_sticky), 64'd0);
        checkOutput("rst_araddr_s", 64'(bus.ARADDR_S), 64'd0);
        checkOutput("slv_idx_fn", slv_idx(64'h0001_0000, 64'(REGION)), 64'd1);
        bus.ARVALID = 1'b0;
        ARESETn = 1'b1;
        stepCycle();

        $display("[TB] single request to slave 0");
        bus.ARREADY_S = 2'b11;
        drive(8'h11, 32'h0000_1234, 4'd2);
        checkOutput("t2_arready", 64'(bus.ARREADY), 64'd1);
        checkOutput("t2_pre_valid", 64'(bus.ARVALID_S), 64'd0);
        stepCycle();
        bus.ARVALID = 1'b0;
        checkOutput("t2_valid", 64'(bus.ARVALID_S), 64'b01);
        checkOutput("t2_addr0", 64'(bus.ARADDR_S[31:0]), 64'h1234);
        checkOutput("t2_addr1", 64'(bus.ARADDR_S[63:32]), 64'h1234);
        checkOutput("t2_id", 64'(bus.ARID_S[7:0]), 64'h11);
        checkOutput("t2_len", 64'(bus.ARLEN_S[3:0]), 64'd2);
        checkOutput("t2_burst", 64'(bus.ARBURST_S[1:0]), 64'(BURST_INCR));
        stepCycle();
        checkOutput("t2_gone", 64'(bus.ARVALID_S), 64'd0);

        $display("[TB] slave 1 stall");
        bus.ARREADY_S = 2'b01;
        drive(8'h22, 32'h0001_0000, 4'd1);
        stepCycle();
        drive(8'h33, 32'h0000_0040, 4'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_valid", 64'(bus.ARVALID_S), 64'b10);
            checkOutput("t3_addr", 64'(bus.ARADDR_S[63:32]), 64'h0001_0000);
            checkOutput("t3_id", 64'(bus.ARID_S[15:8]), 64'h22);
            checkOutput("t3_arready", 64'(bus.ARREADY), 64'd0);
            stepCycle();
        end
        bus.ARREADY_S = 2'b11;
        #1;
        checkOutput("t3_release", 64'(bus.ARREADY), 64'd1);
        stepCycle();
        bus.ARVALID = 1'b0;
        checkOutput("t3_next_valid", 64'(bus.ARVALID_S), 64'b01);
        checkOutput("t3_next_addr", 64'(bus.ARADDR_S[31:0]), 64'h40);
        checkOutput("t3_next_id", 64'(bus.ARID_S[7:0]), 64'h33);
        stepCycle();
        checkOutput("t3_gone", 64'(bus.ARVALID_S), 64'd0);

        $display("[TB] back-to-back");
        for (int j = 0; j < 4; j++) begin
            drive(8'(j), t4Addr[j], 4'd0);
            checkOutput("t4_arready", 64'(bus.ARREADY), 64'd1);
            stepCycle();
            checkOutput("t4_valid", 64'(bus.ARVALID_S), 64'(t4Sel[j]));
            checkOutput("t4_addr", 64'(bus.ARADDR_S[31:0]), 64'(t4Addr[j]));
        end
        bus.ARVALID = 1'b0;
        stepCycle();
        checkOutput("t4_gone", 64'(bus.ARVALID_S), 64'd0);

        $display("[TB] unmapped request");
        drive(8'h5A, 32'h0002_0000, 4'd3);
        stepCycle();
        bus.ARVALID = 1'b0;
        checkOutput("t5_not_fwd", 64'(bus.ARVALID_S), 64'd0);
        checkOutput("t5_arready", 64'(bus.ARREADY), 64'd1);
        stepCycle();
        checkOutput("t5_sticky", 64'(bus.decerr_sticky), 64'd1);
`ifdef DECERR_EN
        beats = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            bus.RREADY_D = (c % 2 == 1);
            #1;
            checkOutput("t5_rvalid", 64'(bus.RVALID_D), 64'd1);
            if (bus.RREADY_D) begin
                checkOutput("t5_rresp", 64'(bus.RRESP_D), 64'b11);
                checkOutput("t5_rid", 64'(bus.RID_D), 64'h5A);
                checkOutput("t5_rdata", 64'(bus.RDATA_D), 64'd0);
                checkOutput("t5_rlast", 64'(bus.RLAST_D), 64'(beats == 3));
                beats++;
            end
            stepCycle();
        end
        checkOutput("t5_beats", 64'(beats), 64'd4);
        checkOutput("t5_done", 64'(bus.RVALID_D), 64'd0);

        $display("[TB] reset mid-burst");
        bus.RREADY_D = 1'b0;
        drive(8'h66, 32'hFFFF_0000, 4'd3);
        stepCycle();
        bus.ARVALID = 1'b0;
        stepCycle();
        bus.RREADY_D = 1'b1;
        #1;
        checkOutput("t6_rvalid", 64'(bus.RVALID_D), 64'd1);
        stepCycle();
        bus.RREADY_D = 1'b0;
        ARESETn = 1'b0;
        stepCycle();
        checkOutput("t6_rst_rvalid", 64'(bus.RVALID_D), 64'd0);
        checkOutput("t6_rst_sticky", 64'(bus.decerr_sticky), 64'd0);
        checkOutput("t6_rst_arready", 64'(bus.ARREADY), 64'd1);
        ARESETn = 1'b1;
        stepCycle();
        checkOutput("t6_idle", 64'(bus.RVALID_D), 64'd0);
        bus.RREADY_D = 1'b1;
        drive(8'h44, 32'h0005_0000, 4'd0);
        stepCycle();
        bus.ARVALID = 1'b0;
        stepCycle();
        checkOutput("t6_single_valid", 64'(bus.RVALID_D), 64'd1);
        checkOutput("t6_single_last", 64'(bus.RLAST_D), 64'd1);
        checkOutput("t6_single_id", 64'(bus.RID_D), 64'h44);
        stepCycle();
        checkOutput("t6_single_done", 64'(bus.RVALID_D), 64'd0);
`else
        for (int c = 0; c < 3; c++) begin
            checkOutput("t5_no_rvalid", 64'(bus.RVALID_D), 64'd0);
            checkOutput("t5_recover", 64'(bus.ARREADY), 64'd1);
            stepCycle();
        end
`endif

        $display("[TB] randomized run");
        bus.RREADY_D = 1'b0;
        prevPend = '0;
        beatCnt = 0;
        rndReady = 1'b1;
        monEn = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r.id    = 8'($urandom);
            r.addr  = 32'($urandom_range(0, 4)) * REGION + 32'($urandom_range(0, REGION - 1));
            if (n % 10 == 9) r.addr = 32'hFFFF_FFF0;
            r.len   = (n % 7 == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            r.size  = 3'($urandom_range(0, 7));
            r.burst = 2'($urandom_range(0, 2));
            r.tgt   = expTgt(r.addr);
            applyStimulus(r);
            repeat ($urandom_range(0, 1)) stepCycle();
        end
        rndReady = 1'b0;
        bus.ARREADY_S = '1;
        bus.RREADY_D = 1'b1;
        for (int w = 0; w < 300 && (mapQ.size() != 0 || errQ.size() != 0); w++) stepCycle();
        repeat (2) stepCycle();
        checkOutput("mapq_empty", 64'(mapQ.size()), 64'd0);
        checkOutput("errq_empty", 64'(errQ.size()), 64'd0);
        checkOutput("final_sticky", 64'(bus.decerr_sticky), 64'd1);
        monEn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
